// File: rtl/cv_bus_deser.sv
// Serial-to-bus deserializer: collects framed serial bits LSB-first and
// presents each completed word through a one-entry valid/ready output buffer.
module cv_bus_deser #(
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             VDD,
    input  logic             VSS,
    input  logic             in,
    input  logic             in_vld,
    input  logic             sof,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-2:0] sr;
    logic             last_bit;
    logic             accept;
    logic             unused_supply;

    // Supply pins exist for netlist compatibility only.
    assign unused_supply = VDD ^ VSS;

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign in_rdy   = !(last_bit && out_vld && !out_rdy);
    assign accept   = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            out     <= '0;
            out_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (out_rdy)
                out_vld <= 1'b0;

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (sof) begin
                            sr    <= '0;
                            sr[0] <= in;
                            cnt   <= CNT_ONE;
                            state <= SHIFT;
                        end
                    end
                    default: begin
                        if (sof && (cnt != '0)) begin
                            // Unexpected frame start: drop the partial word and restart.
                            err   <= 1'b1;
                            sr    <= '0;
                            sr[0] <= in;
                            cnt   <= CNT_ONE;
                        end else if (cnt == CNT_LAST) begin
                            // A completion on the consuming edge overrides the clear above.
                            out     <= {in, sr};
                            out_vld <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            for (int unsigned i = 0; i < WIDTH - 1; i++) begin
                                if (cnt == CNT_W'(i))
                                    sr[i] <= in;
                            end
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv_bus_deser.sv
// Directed self-checking bench for cv_bus_deser at WIDTH=2.
module tb_cv_bus_deser;

    logic       clk;
    logic       rstb;
    logic       vdd;
    logic       vss;
    logic       in;
    logic       in_vld;
    logic       sof;
    logic       in_rdy;
    logic [1:0] out;
    logic       out_vld;
    logic       out_rdy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    cv_bus_deser #(.WIDTH(2)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .VDD     (vdd),
        .VSS     (vss),
        .in      (in),
        .in_vld  (in_vld),
        .sof     (sof),
        .in_rdy  (in_rdy),
        .out     (out),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit across one rising edge, then sample 1 time unit later.
    task automatic send(input logic s, input logic b);
        in_vld = 1'b1;
        sof    = s;
        in     = b;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        sof    = 1'b0;
        in     = 1'b0;
    endtask

    task automatic idle_cycle();
        in_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstb   = 1'b0;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    initial begin
        vdd     = 1'b1;
        vss     = 1'b0;
        rstb    = 1'b0;
        in      = 1'b0;
        in_vld  = 1'b0;
        sof     = 1'b0;
        out_rdy = 1'b0;

        // Reset held for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            in      = 1'($urandom);
            in_vld  = 1'($urandom);
            sof     = 1'($urandom);
            out_rdy = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_vld", 32'(out_vld), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_in_rdy", 32'(in_rdy), 32'h1);
        rstb   = 1'b1;
        in_vld = 1'b0;
        sof    = 1'b0;
        in     = 1'b0;

        // Basic frame
        out_rdy = 1'b1;
        send(1'b1, 1'b1);
        chk("basic_vld_mid", 32'(out_vld), 32'h0);
        send(1'b0, 1'b0);
        chk("basic_out", 32'(out), 32'h1);
        chk("basic_vld", 32'(out_vld), 32'h1);
        chk("basic_err", 32'(err), 32'h0);
        idle_cycle();
        chk("basic_vld_clr", 32'(out_vld), 32'h0);
        chk("basic_out_hold", 32'(out), 32'h1);

        // Pre-frame drop
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1);
            chk("drop_no_vld", 32'(out_vld), 32'h0);
        end
        send(1'b1, 1'b0);
        chk("drop_vld_mid", 32'(out_vld), 32'h0);
        send(1'b0, 1'b1);
        chk("drop_out", 32'(out), 32'h2);
        chk("drop_vld", 32'(out_vld), 32'h1);
        idle_cycle();
        chk("drop_single_word", 32'(out_vld), 32'h0);

        // Backpressure: state is SHIFT with cnt=0, so sof here is a normal start
        out_rdy = 1'b0;
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        chk("bp_out1", 32'(out), 32'h3);
        chk("bp_vld1", 32'(out_vld), 32'h1);
        in_vld = 1'b1; sof = 1'b0; in = 1'b0;
        #1;
        chk("bp_rdy_bit3", 32'(in_rdy), 32'h1);
        @(posedge clk);
        #1;
        in_vld = 1'b1; sof = 1'b0; in = 1'b0;
        #1;
        chk("bp_stall_bit4", 32'(in_rdy), 32'h0);
        @(posedge clk);
        #1;
        chk("bp_hold_out", 32'(out), 32'h3);
        chk("bp_hold_vld", 32'(out_vld), 32'h1);
        chk("bp_still_stalled", 32'(in_rdy), 32'h0);
        out_rdy = 1'b1;
        #1;
        chk("bp_rdy_comb", 32'(in_rdy), 32'h1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("bp_out2", 32'(out), 32'h0);
        chk("bp_vld2", 32'(out_vld), 32'h1);
        chk("bp_err", 32'(err), 32'h0);
        idle_cycle();
        chk("bp_vld_clr", 32'(out_vld), 32'h0);

        // Framing error
        pulse_reset();
        send(1'b1, 1'b1);
        chk("ferr_first", 32'(err), 32'h0);
        send(1'b1, 1'b0);
        chk("ferr_set", 32'(err), 32'h1);
        chk("ferr_no_word", 32'(out_vld), 32'h0);
        send(1'b0, 1'b1);
        chk("ferr_out", 32'(out), 32'h2);
        chk("ferr_vld", 32'(out_vld), 32'h1);
        chk("ferr_sticky", 32'(err), 32'h1);
        idle_cycle();
        chk("ferr_sticky2", 32'(err), 32'h1);

        // Reset mid-word
        send(1'b1, 1'b1);
        pulse_reset();
        chk("rmid_err_clr", 32'(err), 32'h0);
        chk("rmid_out_clr", 32'(out), 32'h0);
        send(1'b0, 1'b0);
        chk("rmid_no_vld", 32'(out_vld), 32'h0);
        idle_cycle();
        chk("rmid_no_vld2", 32'(out_vld), 32'h0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        chk("rmid_next_out", 32'(out), 32'h3);
        chk("rmid_next_vld", 32'(out_vld), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
